// File: rtl/johnson_sequencer.sv
// Johnson (twisted-ring) phase counter with a run/hold/abort sequencer,
// seed loading with validity check and a decoded phase index kept in lockstep.
module johnson_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int PH_W  = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             dir,
    input  logic             hold,
    input  logic             abort,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q,
    output logic [PH_W-1:0]  phase,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             seed_err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             seed_err_q, seed_err_d;

    function automatic logic [WIDTH-1:0] step_code(input logic [WIDTH-1:0] c,
                                                   input logic rev);
        if (rev)
            return {c[WIDTH-2:0], ~c[WIDTH-1]};
        return {~c[0], c[WIDTH-1:1]};
    endfunction

    function automatic logic [PH_W-1:0] step_phase(input logic [PH_W-1:0] p,
                                                   input logic rev);
        if (rev)
            return (p == '0) ? PH_W'(2*WIDTH-1) : p - PH_W'(1);
        return (p == PH_W'(2*WIDTH-1)) ? '0 : p + PH_W'(1);
    endfunction

    // A legal Johnson code has at most one boundary between adjacent bits.
    function automatic logic seed_valid(input logic [WIDTH-1:0] s);
        logic [WIDTH-2:0] edges;
        edges = s[WIDTH-1:1] ^ s[WIDTH-2:0];
        return (edges & (edges - (WIDTH-1)'(1))) == '0;
    endfunction

    // Ones packed at the MSB side count up from 0; ones at the LSB side are
    // the second half of the ring, i.e. 2W minus the number of ones.
    function automatic logic [PH_W-1:0] seed_phase(input logic [WIDTH-1:0] s);
        logic [PH_W-1:0] ones;
        ones = '0;
        for (int i = 0; i < WIDTH; i++)
            ones = ones + PH_W'(s[i]);
        if (s[WIDTH-1] || ones == '0)
            return ones;
        return PH_W'(2*WIDTH-1) - ones + PH_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        aborted_d  = 1'b0;
        seed_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (seed_valid(seed)) begin
                        q_d  = seed;
                        ph_d = seed_phase(seed);
                    end else begin
                        q_d        = '0;
                        ph_d       = '0;
                        seed_err_d = 1'b1;
                    end
                end else if (start) begin
                    if (steps != '0) begin
                        cnt_d   = steps;
                        dir_d   = dir;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (hold) begin
                    state_d = PAUSE;
                end else begin
                    q_d   = step_code(q_q, dir_q);
                    ph_d  = step_phase(ph_q, dir_q);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_d = DONE;
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (!hold) begin
                    state_d = RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN) || (state_d == PAUSE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            q_q        <= '0;
            ph_q       <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign q        = q_q;
    assign phase    = ph_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign seed_err = seed_err_q;

endmodule

// File: tb/tb_johnson_sequencer.sv
// Table-driven bench for johnson_sequencer (WIDTH=4): per-cycle vectors with a
// scoreboard queue, plus a hand-written hold/resume sequence.
module tb_johnson_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, dir, hold, abort, load;
    logic [7:0] steps;
    logic [3:0] seed;
    logic [3:0] q;
    logic [2:0] phase;
    logic       busy, done, aborted, seed_err;

    int checks   = 0;
    int failures = 0;

    johnson_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .steps(steps), .dir(dir),
        .hold(hold), .abort(abort), .load(load), .seed(seed),
        .q(q), .phase(phase), .busy(busy), .done(done),
        .aborted(aborted), .seed_err(seed_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] q;
        logic [2:0] ph;
        logic       b, d, a, s;
    } exp_t;

    typedef struct {
        logic       rst, st;
        logic [7:0] n;
        logic       dr, h, ab, ld;
        logic [3:0] sd;
        exp_t       e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t v(input logic rst, st, input int n, input logic dr, h, ab, ld,
                               input logic [3:0] sd, input logic [3:0] eq, input int eph,
                               input logic eb, ed, ea, es);
        vec_t r;
        r.rst = rst; r.st = st; r.n = 8'(n); r.dr = dr; r.h = h; r.ab = ab; r.ld = ld;
        r.sd = sd;
        r.e = '{q: eq, ph: 3'(eph), b: eb, d: ed, a: ea, s: es};
        return r;
    endfunction

    function automatic vec_t I(input logic [3:0] eq, input int eph, input logic eb, ed, ea, es);
        return v(0, 0, 0, 0, 0, 0, 0, 4'b0000, eq, eph, eb, ed, ea, es);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int idx, input vec_t t);
        exp_t e, act;
        reset = t.rst; start = t.st; steps = t.n; dir = t.dr;
        hold = t.h; abort = t.ab; load = t.ld; seed = t.sd;
        sb.push_back(t.e);
        tick();
        e = sb.pop_front();
        act = '{q: q, ph: phase, b: busy, d: done, a: aborted, s: seed_err};
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL vec%0d: got q=%b ph=%0d busy=%b done=%b ab=%b serr=%b, expected q=%b ph=%0d busy=%b done=%b ab=%b serr=%b",
                     idx, act.q, act.ph, act.b, act.d, act.a, act.s,
                     e.q, e.ph, e.b, e.d, e.a, e.s);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; steps = 0; dir = 0; hold = 0; abort = 0; load = 0; seed = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt, done_cnt, k;
        logic frozen_ok;
        idle_inputs();

        // reset, then 5 forward steps from 0000
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 5, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(I(4'b1000, 1, 1, 0, 0, 0));
        vecs.push_back(I(4'b1100, 2, 1, 0, 0, 0));
        vecs.push_back(I(4'b1110, 3, 1, 0, 0, 0));
        vecs.push_back(I(4'b1111, 4, 1, 0, 0, 0));
        vecs.push_back(I(4'b0111, 5, 0, 1, 0, 0));
        vecs.push_back(I(4'b0111, 5, 0, 0, 0, 0));
        // full wrap of 8 steps, then one reverse step from 0000
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 8, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(I(4'b1000, 1, 1, 0, 0, 0));
        vecs.push_back(I(4'b1100, 2, 1, 0, 0, 0));
        vecs.push_back(I(4'b1110, 3, 1, 0, 0, 0));
        vecs.push_back(I(4'b1111, 4, 1, 0, 0, 0));
        vecs.push_back(I(4'b0111, 5, 1, 0, 0, 0));
        vecs.push_back(I(4'b0011, 6, 1, 0, 0, 0));
        vecs.push_back(I(4'b0001, 7, 1, 0, 0, 0));
        vecs.push_back(I(4'b0000, 0, 0, 1, 0, 0));
        vecs.push_back(I(4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(I(4'b0001, 7, 0, 1, 0, 0));
        vecs.push_back(I(4'b0001, 7, 0, 0, 0, 0));
        // seed loads: invalid, valid, load beats start
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'b1010, 4'b0000, 0, 0, 0, 0, 1));
        vecs.push_back(I(4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'b0011, 4'b0011, 6, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 3, 0, 0, 0, 1, 4'b1100, 4'b1100, 2, 0, 0, 0, 0));
        vecs.push_back(I(4'b1100, 2, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'b1111, 4'b1111, 4, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'b0111, 4'b0111, 5, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'b1001, 4'b0000, 0, 0, 0, 0, 1));
        // abort after 3 steps (abort wins over hold), then zero-step start
        vecs.push_back(v(0, 1, 10, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(I(4'b1000, 1, 1, 0, 0, 0));
        vecs.push_back(I(4'b1100, 2, 1, 0, 0, 0));
        vecs.push_back(I(4'b1110, 3, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b1110, 3, 0, 0, 1, 0));
        vecs.push_back(I(4'b1110, 3, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b1110, 3, 0, 1, 0, 0));
        vecs.push_back(I(4'b1110, 3, 0, 0, 0, 0));
        // abort/hold ignored in IDLE; abort from PAUSE; start while busy ignored
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b1110, 3, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 2, 1, 0, 0, 0, 4'b0000, 4'b1110, 3, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b1110, 3, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 5, 0, 1, 0, 0, 4'b0000, 4'b1110, 3, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b1110, 3, 0, 0, 1, 0));
        vecs.push_back(I(4'b1110, 3, 0, 0, 0, 0));
        // abort beats the final step
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 4'b0000, 4'b1110, 3, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b1110, 3, 0, 0, 1, 0));
        vecs.push_back(I(4'b1110, 3, 0, 0, 0, 0));
        // reset mid-run with start high; steps/dir changes while busy ignored;
        // start/load during DONE ignored
        vecs.push_back(v(0, 1, 4, 1, 0, 0, 0, 4'b0000, 4'b1110, 3, 1, 0, 0, 0));
        vecs.push_back(I(4'b1100, 2, 1, 0, 0, 0));
        vecs.push_back(v(1, 1, 3, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 3, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b1000, 1, 1, 0, 0, 0));
        vecs.push_back(I(4'b1100, 2, 1, 0, 0, 0));
        vecs.push_back(I(4'b1110, 3, 0, 1, 0, 0));
        vecs.push_back(v(0, 1, 2, 0, 0, 0, 1, 4'b0000, 4'b1110, 3, 0, 0, 0, 0));
        vecs.push_back(I(4'b1110, 3, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply(i, vecs[i]);
        check("scoreboard_empty", sb.size(), 0);

        // hold for two cycles after the 2nd step of a 6-step run
        idle_inputs();
        load = 1; seed = 4'b0000;
        tick();
        load = 0; start = 1; steps = 8'd6; dir = 0;
        tick();
        start = 0; steps = 0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        frozen_ok = 1'b1;
        k = 1;
        while (done_cnt == 0 && k < 40) begin
            hold = (k == 3 || k == 4);
            tick();
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if ((k >= 3 && k <= 5) && q != 4'b1100) frozen_ok = 1'b0;
            k++;
        end
        hold = 0;
        check("hold_done_seen", done_cnt, 1);
        check("hold_frozen_1100", int'(frozen_ok), 1);
        check("hold_busy_cycles", busy_cnt, 9);
        check("hold_final_q", int'(q), 4'b0011);
        check("hold_final_phase", int'(phase), 6);
        tick();
        check("hold_done_one_cycle", int'(done), 0);
        check("hold_idle_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
